card_board_select: RTL
======================

// Module: card_board_select
// PURPOSE
//   Board-side counterpart of gameplay_sm. Stores the 16-slot card board that gameplay_sm writes
//   (WriteEnable/dataLoc/dataOut), moves a player cursor over the 4x4 grid from button pulses, and
//   offers the card under the cursor to gameplay_sm via a Select/Ack 4-phase handshake
//   (CardSelectLoc/CardSelectData). Also provides a read port for the VGA renderer.
// PARAMETERS
//   DATA_W   6   card word width: [5]=removed, [4]=face_up, [3:0]=card value
//   LOC_W    4   slot address width (16 slots)
//   COLS     4   grid columns; slot = row*COLS + col
// PORTS
//   Clk             in   1       system clock, all logic rising-edge
//   Reset           in   1       synchronous, active-high
//   WriteEnable     in   1       board write strobe from gameplay_sm
//   dataLoc         in   LOC_W   write address
//   dataOut         in   DATA_W  write data
//   BtnU/BtnD/BtnL/BtnR/BtnC  in  1 each  debounced single-cycle button pulses
//   Ack             in   1       gameplay_sm acknowledge of current selection
//   Select          out  1       selection request to gameplay_sm
//   CardSelectLoc   out  LOC_W   selected slot, stable while Select=1
//   CardSelectData  out  DATA_W  selected slot contents snapshot, stable while Select=1
//   Cursor          out  LOC_W   current cursor slot (for highlighting)
//   RdLoc           in   LOC_W   renderer read address
//   RdData          out  DATA_W  board[RdLoc], combinational
//   RejectCount     out  4       saturating count of refused BtnC presses
// BEHAVIOUR
//   Reset (sync, overrides all): board all 0, Cursor=0, Select=0, CardSelectLoc=0,
//     CardSelectData=0, RejectCount=0, FSM->BROWSE. Reset mid-handshake drops Select next edge.
//   Board write: WriteEnable=1 -> board[dataLoc]<=dataOut at edge, in every FSM state.
//   FSM states: BROWSE, REQ, RELEASE.
//   BROWSE: one move per cycle, priority U>D>L>R; moves wrap within row/column
//     (col0 L->col3, row0 U->row3, etc.). BtnC evaluated on pre-move Cursor:
//     target word[5]=0 and [4]=0 -> latch Loc=Cursor, Data=effective word, Select<=1, ->REQ
//     (Select visible 1 cycle after BtnC); otherwise RejectCount++ (sat at 15), stay BROWSE.
//     Same-cycle BtnC + move: selection uses old cursor, move still applied.
//   Effective word = dataOut if WriteEnable && dataLoc==Cursor that cycle (write bypass), else board.
//   REQ: Select=1, Loc/Data frozen (later writes to that slot do NOT alter snapshot); cursor
//     moves ignored; BtnC ignored (no reject count). Ack=1 sampled -> Select<=0, ->RELEASE.
//   RELEASE: Select=0; wait Ack=0 -> BROWSE (next BtnC accepted from following cycle).
//     Ack already 0 when entering RELEASE still costs one cycle. Ack=1 in BROWSE is ignored.
//   Minimum handshake: BtnC@t, Select@t+1, Ack@t+1 -> Select=0@t+2.
//   RdData purely combinational from board, reflects write from previous edge (no bypass).
// STRUCTURE
//   Shared package/header: card word field indices (REMOVED_BIT=5, FACEUP_BIT=4, VALUE_MSB=3),
//     FSM state encodings, BOARD_SLOTS=16.
//   One sub-module: card_cursor (row/col registers, wrap logic, priority decode, Cursor out).
//   Board is a 16xDATA_W register array in the top; FSM and snapshot regs in the top.
// TESTING
//   1) Reset, write slot5=6'h03, cursor R,D (->5), BtnC -> Select=1 next cycle, Loc=5, Data=6'h03;
//      Ack=1 -> Select=0 next edge; Ack=0 -> BROWSE.
//   2) Cursor at 0: BtnL -> 3, BtnU -> 15, BtnR -> 12, BtnD -> 0 (wrap both axes).
//   3) Slot 2=6'h13 (face-up) and slot 4=6'h21 (removed): BtnC on each -> no Select,
//      RejectCount 0->1->2; 17 rejects total -> RejectCount holds 15.
//   4) Same cycle WriteEnable loc=Cursor=7 data=6'h05 and BtnC -> CardSelectData=6'h05;
//      write 6'h15 to slot 7 during REQ -> CardSelectData stays 6'h05, RdLoc=7 gives 6'h15.
//   5) Hold Ack=1 through RELEASE, press BtnC -> ignored, no Select until Ack=0 then new BtnC.
//   6) Assert Reset while Select=1 -> next edge Select=0, board cleared, Cursor=0, FSM BROWSE.

Source files
------------

// File: rtl/card_board_select_pkg.sv
// rtl/card_board_select_pkg.sv - shared widths, card word fields and FSM states for the card board
package card_board_select_pkg;

  localparam int DATA_W      = 6;
  localparam int LOC_W       = 4;
  localparam int COLS        = 4;
  localparam int BOARD_SLOTS = 16;
  localparam int ROWS        = BOARD_SLOTS / COLS;
  localparam int ROW_W       = 2;
  localparam int COL_W       = 2;

  // Card word layout: [5]=removed, [4]=face_up, [3:0]=value
  localparam int REMOVED_BIT = 5;
  localparam int FACEUP_BIT  = 4;
  localparam int VALUE_MSB   = 3;

  localparam logic [3:0] REJECT_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_BROWSE  = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // A card can be offered only while it is still on the board and face down
  function automatic logic card_selectable(input logic [DATA_W-1:0] word);
    return !word[REMOVED_BIT] && !word[FACEUP_BIT];
  endfunction

  function automatic logic [VALUE_MSB:0] card_value(input logic [DATA_W-1:0] word);
    return word[VALUE_MSB:0];
  endfunction

endpackage

// File: rtl/card_board_select_if.sv
// rtl/card_board_select_if.sv - board write bus and select/ack handshake shared with gameplay_sm
interface card_board_select_if;
  import card_board_select_pkg::*;

  logic              WriteEnable;
  logic [LOC_W-1:0]  dataLoc;
  logic [DATA_W-1:0] dataOut;
  logic              Ack;
  logic              Select;
  logic [LOC_W-1:0]  CardSelectLoc;
  logic [DATA_W-1:0] CardSelectData;

  // gameplay_sm side: writes the board and acknowledges selections
  modport master (
    output WriteEnable, dataLoc, dataOut, Ack,
    input  Select, CardSelectLoc, CardSelectData
  );

  // board side: stores writes and raises selections
  modport slave (
    input  WriteEnable, dataLoc, dataOut, Ack,
    output Select, CardSelectLoc, CardSelectData
  );

endinterface

// File: rtl/card_cursor.sv
// rtl/card_cursor.sv - 4x4 player cursor with wrapping moves and U>D>L>R priority
module card_cursor
  import card_board_select_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             move_en,
  input  logic             btn_u,
  input  logic             btn_d,
  input  logic             btn_l,
  input  logic             btn_r,
  output logic [LOC_W-1:0] cursor
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  // Apply at most one move per cycle; each axis wraps independently
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (move_en) begin
      if (btn_u) begin
        row_d = (row_q == '0) ? ROW_LAST : row_q - 1'b1;
      end else if (btn_d) begin
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else if (btn_l) begin
        col_d = (col_q == '0) ? COL_LAST : col_q - 1'b1;
      end else if (btn_r) begin
        col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      end
    end
  end

  // Row/column registers, cleared to the top-left slot on reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Slot index = row*COLS + col
  always_comb begin
    cursor = LOC_W'(row_q) * LOC_W'(COLS) + LOC_W'(col_q);
  end

endmodule

// File: rtl/card_board_select.sv
// rtl/card_board_select.sv - card board storage, cursor and select/ack offer to gameplay_sm
module card_board_select
  import card_board_select_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  card_board_select_if.slave  gp,
  input  logic                BtnU,
  input  logic                BtnD,
  input  logic                BtnL,
  input  logic                BtnR,
  input  logic                BtnC,
  output logic [LOC_W-1:0]    Cursor,
  input  logic [LOC_W-1:0]    RdLoc,
  output logic [DATA_W-1:0]   RdData,
  output logic [3:0]          RejectCount
);

  logic [DATA_W-1:0] board_q [BOARD_SLOTS];
  logic [DATA_W-1:0] board_d [BOARD_SLOTS];

  state_e            state_q, state_d;
  logic              select_q, select_d;
  logic [LOC_W-1:0]  loc_q, loc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        reject_q, reject_d;
  logic [DATA_W-1:0] eff_word;

  // Cursor only moves while browsing; selection and release freeze it
  card_cursor u_cursor (
    .Clk     (Clk),
    .Reset   (Reset),
    .move_en (state_q == ST_BROWSE),
    .btn_u   (BtnU),
    .btn_d   (BtnD),
    .btn_l   (BtnL),
    .btn_r   (BtnR),
    .cursor  (Cursor)
  );

  // Board writes land in every FSM state
  always_comb begin
    board_d = board_q;
    if (gp.WriteEnable) begin
      board_d[gp.dataLoc] = gp.dataOut;
    end
  end

  // Word under the pre-move cursor, including a same-cycle write to that slot
  always_comb begin
    eff_word = board_q[Cursor];
    if (gp.WriteEnable && (gp.dataLoc == Cursor)) begin
      eff_word = gp.dataOut;
    end
  end

  // Next-state logic for the select/ack handshake, snapshot and reject counter
  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    loc_d    = loc_q;
    data_d   = data_q;
    reject_d = reject_q;
    case (state_q)
      ST_BROWSE: begin
        if (BtnC) begin
          if (card_selectable(eff_word)) begin
            loc_d    = Cursor;
            data_d   = eff_word;
            select_d = 1'b1;
            state_d  = ST_REQ;
          end else if (reject_q != REJECT_MAX) begin
            reject_d = reject_q + 4'd1;
          end
        end
      end
      ST_REQ: begin
        if (gp.Ack) begin
          select_d = 1'b0;
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!gp.Ack) begin
          state_d = ST_BROWSE;
        end
      end
      default: begin
        select_d = 1'b0;
        state_d  = ST_BROWSE;
      end
    endcase
  end

  // FSM, registered handshake outputs and board array
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_BROWSE;
      select_q <= 1'b0;
      loc_q    <= '0;
      data_q   <= '0;
      reject_q <= '0;
      board_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      loc_q    <= loc_d;
      data_q   <= data_d;
      reject_q <= reject_d;
      board_q  <= board_d;
    end
  end

  // Renderer port sees only committed board contents
  always_comb begin
    RdData            = board_q[RdLoc];
    gp.Select         = select_q;
    gp.CardSelectLoc  = loc_q;
    gp.CardSelectData = data_q;
    RejectCount       = reject_q;
  end

endmodule
